// File: rtl/wbsplitter_if.sv
// Bus bundle for the 1-to-2 Wishbone splitter. Signal names are written
// from the splitter's point of view: i_* flow into it, o_* flow out of it.
interface wbsplitter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  // Upstream master request
  logic            i_cyc;
  logic            i_stb;
  logic            i_we;
  logic [AW-1:0]   i_adr;
  logic [DW-1:0]   i_dat;
  logic [DW/8-1:0] i_sel;
  // Upstream responses
  logic            o_stall;
  logic            o_ack;
  logic            o_err;
  logic [DW-1:0]   o_data;
  // Slave-side strobes and cycles
  logic            o_a_cyc;
  logic            o_a_stb;
  logic            o_b_cyc;
  logic            o_b_stb;
  // Request fields broadcast to both slaves
  logic            o_we;
  logic [AW-1:0]   o_adr;
  logic [DW-1:0]   o_dat;
  logic [DW/8-1:0] o_sel;
  // Slave A responses
  logic            i_a_ack;
  logic            i_a_stall;
  logic            i_a_err;
  logic [DW-1:0]   i_a_data;
  // Slave B responses
  logic            i_b_ack;
  logic            i_b_stall;
  logic            i_b_err;
  logic [DW-1:0]   i_b_data;

  // The splitter itself
  modport slave (
    input  i_cyc, i_stb, i_we, i_adr, i_dat, i_sel,
    input  i_a_ack, i_a_stall, i_a_err, i_a_data,
    input  i_b_ack, i_b_stall, i_b_err, i_b_data,
    output o_stall, o_ack, o_err, o_data,
    output o_a_cyc, o_a_stb, o_b_cyc, o_b_stb,
    output o_we, o_adr, o_dat, o_sel
  );

  // The surrounding environment (upstream master plus both slaves)
  modport master (
    output i_cyc, i_stb, i_we, i_adr, i_dat, i_sel,
    output i_a_ack, i_a_stall, i_a_err, i_a_data,
    output i_b_ack, i_b_stall, i_b_err, i_b_data,
    input  o_stall, o_ack, o_err, o_data,
    input  o_a_cyc, o_a_stb, o_b_cyc, o_b_stb,
    input  o_we, o_adr, o_dat, o_sel
  );
endinterface

// File: rtl/wbsplitter.sv
// Wishbone pipelined 1-master-to-2-slave splitter. Each request is steered
// to slave A or B by address window; an outstanding counter keeps returns
// bound to the slave that was addressed, and a request to the other slave
// waits until everything in flight has come back (no reordering).
// Addresses hitting neither window get a one-cycle error and abort the cycle.
module wbsplitter #(
  parameter int            DW      = 32,
  parameter int            AW      = 32,
  parameter logic [AW-1:0] A_BASE  = 32'h0000_0000,
  parameter logic [AW-1:0] A_MASK  = 32'h8000_0000,
  parameter logic [AW-1:0] B_BASE  = 32'h8000_0000,
  parameter logic [AW-1:0] B_MASK  = 32'h8000_0000,
  parameter int            LGDEPTH = 3
) (
  input logic         i_clk,
  input logic         i_reset_n,
  wbsplitter_if.slave bus
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2,
    SEL_BAD  = 2'd3
  } sel_t;

  // Counter saturates one short of wrap: that is the in-flight limit
  localparam logic [LGDEPTH-1:0] COUNT_MAX = '1;

  sel_t               r_sel, sel_next;
  logic [LGDEPTH-1:0] r_count, count_next;
  logic               r_abort, abort_next;
  logic               r_bad_err, bad_err_next;

  sel_t dec;
  sel_t sel;
  logic idle;
  logic grant;
  logic stall;
  logic accept;
  logic to_slave;
  logic fwd_ack;
  logic slv_err;

  // Address decode, slave selection, grant and handshake qualifiers
  always_comb begin
    if ((bus.i_adr & A_MASK) == A_BASE)
      dec = SEL_A;
    else if ((bus.i_adr & B_MASK) == B_BASE)
      dec = SEL_B;
    else
      dec = SEL_BAD;

    idle  = (r_count == '0);
    // While requests are in flight the target is locked to the previous one
    sel   = idle ? dec : r_sel;
    grant = bus.i_stb && !r_abort && !r_bad_err &&
            (idle || (dec == r_sel && r_count != COUNT_MAX));
    // BAD requests never see a slave stall, only a missing grant
    stall = bus.i_stb && (!grant ||
            (sel == SEL_A && bus.i_a_stall) ||
            (sel == SEL_B && bus.i_b_stall));
    accept   = bus.i_cyc && bus.i_stb && !stall;
    to_slave = accept && (sel == SEL_A || sel == SEL_B);
    // Returns are honoured only from the locked slave with work outstanding
    fwd_ack  = !idle && ((r_sel == SEL_A && bus.i_a_ack) ||
                         (r_sel == SEL_B && bus.i_b_ack));
    slv_err  = !idle && ((r_sel == SEL_A && bus.i_a_err) ||
                         (r_sel == SEL_B && bus.i_b_err));
  end

  // State register: selection, in-flight count, abort and pending BAD error
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sel     <= SEL_NONE;
      r_count   <= '0;
      r_abort   <= 1'b0;
      r_bad_err <= 1'b0;
    end else begin
      r_sel     <= sel_next;
      r_count   <= count_next;
      r_abort   <= abort_next;
      r_bad_err <= bad_err_next;
    end
  end

  // Next-state: count accepts against forwarded acks, handle errors and aborts
  always_comb begin
    sel_next     = r_sel;
    count_next   = r_count;
    abort_next   = r_abort;
    bad_err_next = 1'b0;
    if (!bus.i_cyc) begin
      // Dropping cyc abandons everything; late slave returns become orphans
      sel_next   = SEL_NONE;
      count_next = '0;
      abort_next = 1'b0;
    end else begin
      bad_err_next = accept && (sel == SEL_BAD);
      // The BAD error pulse is followed by an abort lasting until cyc falls
      if (r_bad_err)
        abort_next = 1'b1;
      if (slv_err) begin
        count_next = '0;
        abort_next = 1'b1;
      end else if (to_slave && !fwd_ack) begin
        count_next = r_count + LGDEPTH'(1);
      end else if (!to_slave && fwd_ack) begin
        count_next = r_count - LGDEPTH'(1);
      end
      if (accept)
        sel_next = sel;
    end
  end

  // Outputs: zero-latency request steering and response return paths
  always_comb begin
    bus.o_we    = bus.i_we;
    bus.o_adr   = bus.i_adr;
    bus.o_dat   = bus.i_dat;
    bus.o_sel   = bus.i_sel;
    bus.o_stall = stall;
    bus.o_a_stb = i_reset_n && bus.i_cyc && bus.i_stb && grant && (sel == SEL_A);
    bus.o_b_stb = i_reset_n && bus.i_cyc && bus.i_stb && grant && (sel == SEL_B);
    bus.o_a_cyc = i_reset_n && bus.i_cyc && !r_abort && (sel == SEL_A) &&
                  (bus.i_stb || !idle);
    bus.o_b_cyc = i_reset_n && bus.i_cyc && !r_abort && (sel == SEL_B) &&
                  (bus.i_stb || !idle);
    bus.o_ack   = i_reset_n && fwd_ack;
    bus.o_err   = i_reset_n && (r_bad_err || slv_err);
    bus.o_data  = (r_sel == SEL_B) ? bus.i_b_data : bus.i_a_data;
  end

endmodule

// File: tb/tb_wbsplitter.sv
// Randomized bench for wbsplitter. A random upstream master and two random
// slave models drive the bus; a transaction-level reference (queue of
// outstanding requests with their expected return data) predicts every
// handshake output each cycle.
module tb_wbsplitter;

  localparam int          DW     = 32;
  localparam int          AW     = 32;
  localparam int          LGD    = 3;
  localparam int          MAXOUT = (1 << LGD) - 1;
  localparam logic [31:0] A_BASE = 32'h0000_0000;
  localparam logic [31:0] A_MASK = 32'hF000_0000;
  localparam logic [31:0] B_BASE = 32'h1000_0000;
  localparam logic [31:0] B_MASK = 32'hF000_0000;
  localparam int          NPH    = 8;
  localparam int          PH_LEN = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wbsplitter_if #(.DW(DW), .AW(AW)) bus ();

  wbsplitter #(
    .DW(DW), .AW(AW),
    .A_BASE(A_BASE), .A_MASK(A_MASK),
    .B_BASE(B_BASE), .B_MASK(B_MASK),
    .LGDEPTH(LGD)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;
  int txn_no = 0;

  // Reference: target of the current burst (0 none, 1 A, 2 B, 3 bad),
  // expected return data of every outstanding request, error/abort flags
  int          m_cur = 0;
  logic        m_bad_err = 1'b0;
  logic        m_abort = 1'b0;
  logic [31:0] inflight[$];

  // Slave models: queue of values each slave owes back
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  // Phase knobs (percent)
  int p_ack, p_stall, p_err, p_stb, p_drop, p_switch;
  bit bad_ok;
  int tgt_pick = 1;

  int tab_ack[NPH]    = '{50,   0, 90, 30,  20, 60, 100, 40};
  int tab_stall[NPH]  = '{10,   0,  0, 40,  10, 20,   0, 30};
  int tab_err[NPH]    = '{ 0,   0,  0,  3,   0,  5,   0,  2};
  int tab_stb[NPH]    = '{70, 100,100, 80, 100, 60, 100, 90};
  int tab_drop[NPH]   = '{ 2,   0,  1,  2,   3,  2,   2,  4};
  int tab_switch[NPH] = '{20,   0, 30, 20,  50, 10,  40, 30};
  bit tab_bad[NPH]    = '{ 1,   0,  1,  1,   1,  0,   1,  1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cycle_no, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    if ((a & A_MASK) == A_BASE) return 1;
    if ((a & B_MASK) == B_BASE) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] resp_val(input int t, input logic [31:0] a);
    return a ^ ((t == 1) ? 32'hA0A0_0000 : 32'hB0B0_0000);
  endfunction

  function automatic int pick_target(input bit allow_bad);
    int r;
    r = $urandom_range(99);
    if (allow_bad && r < 10) return 3;
    if (r < 60) return 1;
    return 2;
  endfunction

  task automatic slave_drive(input int n, input logic [31:0] front,
                             output logic stall, output logic ack,
                             output logic err, output logic [31:0] data);
    stall = ($urandom_range(99) < p_stall);
    if (n > 0) begin
      err  = ($urandom_range(99) < p_err);
      ack  = !err && ($urandom_range(99) < p_ack);
      data = front;
    end else begin
      // Occasional stray ack from an idle slave must never reach upstream
      err  = 1'b0;
      ack  = ($urandom_range(99) < 3);
      data = 32'hDEAD_0000 | 32'($urandom_range(255));
    end
  endtask

  task automatic clear_all();
    inflight.delete();
    qa.delete();
    qb.delete();
    m_cur = 0;
    m_bad_err = 1'b0;
    m_abort = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ack"},   32'(bus.o_ack),   32'd0);
    check_val({tag, "_err"},   32'(bus.o_err),   32'd0);
    check_val({tag, "_a_cyc"}, 32'(bus.o_a_cyc), 32'd0);
    check_val({tag, "_b_cyc"}, 32'(bus.o_b_cyc), 32'd0);
    check_val({tag, "_a_stb"}, 32'(bus.o_a_stb), 32'd0);
    check_val({tag, "_b_stb"}, 32'(bus.o_b_stb), 32'd0);
  endtask

  // Hold reset while the bus is busy: every handshake output must stay low
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_cyc = 1'b1; bus.i_stb = 1'b1; bus.i_adr = 32'h0000_0010;
    bus.i_a_ack = 1'b1; bus.i_b_ack = 1'b1;
    bus.i_a_err = 1'b0; bus.i_b_err = 1'b0;
    #1;
    check_quiet("reset");
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_cyc = 1'b0; bus.i_stb = 1'b0;
    bus.i_a_ack = 1'b0; bus.i_b_ack = 1'b0;
  endtask

  task automatic run_cycle(input bit force_drop);
    logic [31:0] r, adr;
    logic        cyc, stb;
    logic        s_stall, s_ack, s_err;
    logic [31:0] s_data;
    int          n_out, tgt, route;
    logic        blocked, e_stall, e_astb, e_bstb, e_acyc, e_bcyc;
    logic        a_ret, b_ret, e_ack, s_errd, e_err, acc;

    @(negedge clk);
    cycle_no++;

    // Upstream master
    cyc = !force_drop && ($urandom_range(99) >= p_drop);
    stb = cyc && ($urandom_range(99) < p_stb);
    if ($urandom_range(99) < p_switch) tgt_pick = pick_target(bad_ok);
    r = $urandom;
    case (tgt_pick)
      1:       adr = {4'h0, r[27:2], 2'b00};
      2:       adr = {4'h1, r[27:2], 2'b00};
      default: adr = {4'($urandom_range(15, 2)), r[27:2], 2'b00};
    endcase
    bus.i_cyc = cyc;
    bus.i_stb = stb;
    bus.i_adr = adr;
    bus.i_we  = 1'($urandom_range(1));
    bus.i_dat = $urandom;
    bus.i_sel = 4'($urandom_range(15));

    // Slaves
    slave_drive(qa.size(), (qa.size() > 0) ? qa[0] : 32'h0, s_stall, s_ack, s_err, s_data);
    bus.i_a_stall = s_stall; bus.i_a_ack = s_ack; bus.i_a_err = s_err; bus.i_a_data = s_data;
    slave_drive(qb.size(), (qb.size() > 0) ? qb[0] : 32'h0, s_stall, s_ack, s_err, s_data);
    bus.i_b_stall = s_stall; bus.i_b_ack = s_ack; bus.i_b_err = s_err; bus.i_b_data = s_data;

    #1;

    // Reference prediction
    n_out   = inflight.size();
    tgt     = decode(adr);
    route   = (n_out == 0) ? tgt : m_cur;
    blocked = m_abort || m_bad_err ||
              (n_out > 0 && (tgt != m_cur || n_out == MAXOUT));
    e_stall = stb && (blocked || (route == 1 && bus.i_a_stall) ||
                                 (route == 2 && bus.i_b_stall));
    e_astb  = cyc && stb && !blocked && route == 1;
    e_bstb  = cyc && stb && !blocked && route == 2;
    e_acyc  = cyc && !m_abort && route == 1 && (stb || n_out > 0);
    e_bcyc  = cyc && !m_abort && route == 2 && (stb || n_out > 0);
    a_ret   = (n_out > 0) && m_cur == 1;
    b_ret   = (n_out > 0) && m_cur == 2;
    e_ack   = (a_ret && bus.i_a_ack) || (b_ret && bus.i_b_ack);
    s_errd  = (a_ret && bus.i_a_err) || (b_ret && bus.i_b_err);
    e_err   = m_bad_err || s_errd;

    check_val("stall", 32'(bus.o_stall), 32'(e_stall));
    check_val("a_stb", 32'(bus.o_a_stb), 32'(e_astb));
    check_val("b_stb", 32'(bus.o_b_stb), 32'(e_bstb));
    check_val("a_cyc", 32'(bus.o_a_cyc), 32'(e_acyc));
    check_val("b_cyc", 32'(bus.o_b_cyc), 32'(e_bcyc));
    check_val("ack",   32'(bus.o_ack),   32'(e_ack));
    check_val("err",   32'(bus.o_err),   32'(e_err));
    check_val("adr",   bus.o_adr, adr);
    check_val("dat",   bus.o_dat, bus.i_dat);
    check_val("we_sel", {27'd0, bus.o_we, bus.o_sel}, {27'd0, bus.i_we, bus.i_sel});
    if (e_ack && n_out > 0)
      check_val("rdata", bus.o_data, inflight[0]);

    // Slave models consume what the DUT actually presented to them
    if (bus.i_a_ack && qa.size() > 0) void'(qa.pop_front());
    if (bus.o_a_stb && !bus.i_a_stall) qa.push_back(resp_val(1, bus.o_adr));
    if (bus.i_a_err || !bus.o_a_cyc) qa.delete();
    if (bus.i_b_ack && qb.size() > 0) void'(qb.pop_front());
    if (bus.o_b_stb && !bus.i_b_stall) qb.push_back(resp_val(2, bus.o_adr));
    if (bus.i_b_err || !bus.o_b_cyc) qb.delete();

    // Reference state advance
    if (!cyc) begin
      inflight.delete();
      m_cur = 0;
      m_bad_err = 1'b0;
      m_abort = 1'b0;
    end else begin
      acc = stb && !e_stall;
      if (m_bad_err) m_abort = 1'b1;
      m_bad_err = acc && route == 3;
      if (s_errd) begin
        inflight.delete();
        m_abort = 1'b1;
      end else begin
        if (e_ack) void'(inflight.pop_front());
        if (acc && route != 3) inflight.push_back(resp_val(route, adr));
      end
      if (acc) begin
        m_cur = route;
        txn_no++;
        $display("txn %0d cycle=%0d adr=%h we=%0b -> %s", txn_no, cycle_no, adr,
                 bus.i_we, (route == 1) ? "A" : (route == 2) ? "B" : "bad");
      end
    end
  endtask

  initial begin
    bus.i_cyc = 1'b0; bus.i_stb = 1'b0; bus.i_we = 1'b0;
    bus.i_adr = '0; bus.i_dat = '0; bus.i_sel = '0;
    bus.i_a_ack = 1'b0; bus.i_a_stall = 1'b0; bus.i_a_err = 1'b0; bus.i_a_data = '0;
    bus.i_b_ack = 1'b0; bus.i_b_stall = 1'b0; bus.i_b_err = 1'b0; bus.i_b_data = '0;
    rst_n = 1'b0;

    reset_pulse();

    for (int ph = 0; ph < NPH; ph++) begin
      p_ack    = tab_ack[ph];
      p_stall  = tab_stall[ph];
      p_err    = tab_err[ph];
      p_stb    = tab_stb[ph];
      p_drop   = tab_drop[ph];
      p_switch = tab_switch[ph];
      bad_ok   = tab_bad[ph];
      tgt_pick = bad_ok ? pick_target(1'b1) : 1;
      for (int c = 0; c < PH_LEN; c++) begin
        run_cycle(c == 0);
        if (ph == 4 && c == PH_LEN / 2) reset_pulse();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
